// File: rtl/spi_slave.sv
// SPI mode-0 slave endpoint.
// SCLK, CS and MOSI are oversampled on clk through synchronizer chains.
// Each byte from the master is shifted in MSB first. A preloaded response
// byte is shifted out on MISO at the same time. done pulses for one cycle
// each time a complete byte lands in slaveDataReceived.
module spi_slave #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] slaveDataToSend,
  output logic [DATA_WIDTH-1:0] slaveDataReceived,
  output logic                  done,
  output logic                  busy
);

  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state;
  logic [SYNC_STAGES-1:0]  sclkSync;
  logic [SYNC_STAGES-1:0]  csSync;
  logic [SYNC_STAGES-1:0]  mosiSync;
  logic                    sclkPrev;
  logic                    csPrev;
  logic [DATA_WIDTH-1:0]   txBuf;
  logic [DATA_WIDTH-1:0]   shiftTx;
  logic [DATA_WIDTH-2:0]   shiftRx;
  logic [CNT_W-1:0]        bitCnt;

  logic                    sclkS;
  logic                    csS;
  logic                    mosiS;
  logic                    sclkRise;
  logic                    sclkFall;
  logic                    csFall;
  logic [DATA_WIDTH-1:0]   txNext;
  logic [DATA_WIDTH-1:0]   rxFull;

  assign sclkS    = sclkSync[SYNC_STAGES-1];
  assign csS      = csSync[SYNC_STAGES-1];
  assign mosiS    = mosiSync[SYNC_STAGES-1];
  assign sclkRise = sclkS & ~sclkPrev;
  assign sclkFall = ~sclkS & sclkPrev;
  assign csFall   = ~csS & csPrev;

  // A load arriving in the same cycle as a reload wins over the stored buffer.
  assign txNext = load ? slaveDataToSend : txBuf;

  // Complete byte: the bits already collected plus the bit arriving now.
  assign rxFull = {shiftRx, mosiS};

  // Synchronizer chains and previous-sample registers for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclkSync <= '0;
      mosiSync <= '0;
      csSync   <= '1;
      sclkPrev <= 1'b0;
      csPrev   <= 1'b1;
    end else begin
      sclkSync <= {sclkSync[SYNC_STAGES-2:0], SCLK};
      mosiSync <= {mosiSync[SYNC_STAGES-2:0], MOSI};
      csSync   <= {csSync[SYNC_STAGES-2:0], CS};
      sclkPrev <= sclkS;
      csPrev   <= csS;
    end
  end

  // Response buffer; a load is accepted in any state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txBuf <= '0;
    end else if (load) begin
      txBuf <= slaveDataToSend;
    end
  end

  // Transfer state machine with registered MISO, busy, done and received byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      MISO              <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      slaveDataReceived <= '0;
      shiftTx           <= '0;
      shiftRx           <= '0;
      bitCnt            <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          MISO <= 1'b0;
          if (csFall) begin
            shiftTx <= txNext;
            MISO    <= txNext[DATA_WIDTH-1];
            bitCnt  <= '0;
            busy    <= 1'b1;
            state   <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (csS) begin
            // Deselect always wins; a partial byte is simply dropped.
            state  <= IDLE;
            busy   <= 1'b0;
            MISO   <= 1'b0;
            bitCnt <= '0;
          end else begin
            busy <= 1'b1;
            if (sclkRise) begin
              shiftRx <= rxFull[DATA_WIDTH-2:0];
              if (bitCnt == LAST_BIT) begin
                slaveDataReceived <= rxFull;
                done              <= 1'b1;
                bitCnt            <= '0;
                // Reload for a back-to-back byte; MISO follows on the next fall.
                shiftTx           <= txNext;
              end else begin
                bitCnt <= bitCnt + CNT_W'(1);
              end
            end else if (sclkFall) begin
              if (bitCnt != '0) begin
                shiftTx <= {shiftTx[DATA_WIDTH-2:0], 1'b0};
                MISO    <= shiftTx[DATA_WIDTH-2];
              end else begin
                MISO <= shiftTx[DATA_WIDTH-1];
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          MISO  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bench-side SPI master drives bytes,
// a transaction-level model predicts the response stream, received bytes,
// done timing and busy, and a per-cycle compare process checks the DUT.
module tb_spi_slave;

  localparam int DW   = 8;
  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          SCLK = 1'b0;
  logic          CS = 1'b1;
  logic          MOSI = 1'b0;
  logic          MISO;
  logic          load = 1'b0;
  logic [DW-1:0] slaveDataToSend = '0;
  logic [DW-1:0] slaveDataReceived;
  logic          done;
  logic          busy;

  spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(SYNC)) dut (
    .clk               (clk),
    .reset             (reset),
    .SCLK              (SCLK),
    .CS                (CS),
    .MOSI              (MOSI),
    .MISO              (MISO),
    .load              (load),
    .slaveDataToSend   (slaveDataToSend),
    .slaveDataReceived (slaveDataReceived),
    .done              (done),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  int cycleCnt = 0;
  always @(posedge clk) cycleCnt++;

  int testsRun    = 0;
  int testsFailed = 0;

  // Model state
  int            halfPer = 4;
  logic [DW-1:0] txModel = '0;
  logic [DW-1:0] modelRx = '0;
  int            expCyc[$];
  logic [DW-1:0] expData[$];
  logic [7:0]    csHist = '1;
  int            validCnt = 0;
  bit            expDone;
  bit            expBusy;
  logic [DW-1:0] lastTxByte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    csHist = {csHist[6:0], CS};
    if (reset) begin
      validCnt = 0;
      modelRx  = '0;
      expCyc.delete();
      expData.delete();
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_miso", {31'd0, MISO}, 32'd0);
      check("rst_rx", {24'd0, slaveDataReceived}, 32'd0);
    end else begin
      validCnt++;
      expDone = 1'b0;
      if (expCyc.size() > 0 && expCyc[0] <= cycleCnt) begin
        expDone = (expCyc[0] == cycleCnt);
        modelRx = expData[0];
        void'(expCyc.pop_front());
        void'(expData.pop_front());
      end
      check("done", {31'd0, done}, {31'd0, expDone});
      check("rx_data", {24'd0, slaveDataReceived}, {24'd0, modelRx});
      if (validCnt > LAT) begin
        expBusy = !csHist[LAT];
        check("busy", {31'd0, busy}, {31'd0, expBusy});
        if (!expBusy) check("miso_idle", {31'd0, MISO}, 32'd0);
      end
    end
  end

  task automatic pulseLoad(input logic [DW-1:0] val);
    @(posedge clk); #1;
    load = 1'b1;
    slaveDataToSend = val;
    txModel = val;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  // Drop CS; optionally pulse load in the exact cycle the synced fall is seen.
  task automatic startCs(input bit collide, input logic [DW-1:0] colVal);
    CS = 1'b0;
    repeat (SYNC) @(posedge clk);
    #1;
    if (collide) begin
      load = 1'b1;
      slaveDataToSend = colVal;
      txModel = colVal;
    end
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic endCs();
    repeat (halfPer) @(posedge clk);
    #1;
    CS = 1'b1;
    repeat (halfPer + 2) @(posedge clk);
    #1;
  endtask

  // Send nBits of a byte MSB first; a full byte expects a done pulse and
  // the response byte that was buffered when the byte started.
  task automatic sendByte(input logic [DW-1:0] mosiByte, input int nBits,
                          input bit midLoad, input logic [DW-1:0] midVal);
    logic [DW-1:0] expTx;
    logic [DW-1:0] gotTx;
    expTx = txModel;
    gotTx = '0;
    for (int i = 0; i < nBits; i++) begin
      MOSI = mosiByte[DW-1-i];
      repeat (halfPer) @(posedge clk);
      #1;
      gotTx[DW-1-i] = MISO;
      SCLK = 1'b1;
      if (i == DW - 1) begin
        expCyc.push_back(cycleCnt + LAT);
        expData.push_back(mosiByte);
      end
      if (midLoad && i == 3) begin
        @(posedge clk); #1;
        load = 1'b1;
        slaveDataToSend = midVal;
        txModel = midVal;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (halfPer - 2) @(posedge clk);
        #1;
      end else begin
        repeat (halfPer) @(posedge clk);
        #1;
      end
      SCLK = 1'b0;
    end
    if (nBits == DW) begin
      lastTxByte = gotTx;
      check("miso_byte", {24'd0, gotTx}, {24'd0, expTx});
      $display("[TB] byte mosi=%02h miso=%02h expected_miso=%02h", mosiByte, gotTx, expTx);
    end else begin
      $display("[TB] partial byte mosi=%02h bits=%0d", mosiByte, nBits);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nBytes;
    int nBits;
    bit abortIt;
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("init_miso", {31'd0, MISO}, 32'd0);
    check("init_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Basic byte
    pulseLoad(8'h09);
    startCs(1'b0, 8'h00);
    sendByte(8'h53, DW, 1'b0, 8'h00);
    endCs();
    check("basic_miso", {24'd0, lastTxByte}, 32'h09);
    check("basic_rx", {24'd0, slaveDataReceived}, 32'h53);

    // Second vector, busy framing
    pulseLoad(8'h98);
    startCs(1'b0, 8'h00);
    check("busy_active", {31'd0, busy}, 32'd1);
    sendByte(8'h3C, DW, 1'b0, 8'h00);
    endCs();
    check("second_miso", {24'd0, lastTxByte}, 32'h98);
    check("second_rx", {24'd0, slaveDataReceived}, 32'h3C);
    check("busy_after", {31'd0, busy}, 32'd0);

    // Back-to-back with a load during byte 1
    pulseLoad(8'h22);
    startCs(1'b0, 8'h00);
    sendByte(8'h53, DW, 1'b1, 8'h83);
    check("b2b_miso1", {24'd0, lastTxByte}, 32'h22);
    sendByte(8'h3C, DW, 1'b0, 8'h00);
    check("b2b_miso2", {24'd0, lastTxByte}, 32'h83);
    endCs();
    check("b2b_rx", {24'd0, slaveDataReceived}, 32'h3C);

    // Abort after 5 bits, then a full transfer
    pulseLoad(8'hC2);
    startCs(1'b0, 8'h00);
    sendByte(8'hA5, 5, 1'b0, 8'h00);
    endCs();
    check("abort_rx", {24'd0, slaveDataReceived}, 32'h3C);
    check("abort_miso", {31'd0, MISO}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    startCs(1'b0, 8'h00);
    sendByte(8'h5A, DW, 1'b0, 8'h00);
    endCs();
    check("post_abort_miso", {24'd0, lastTxByte}, 32'hC2);
    check("post_abort_rx", {24'd0, slaveDataReceived}, 32'h5A);

    // Reset mid-transfer
    pulseLoad(8'h66);
    startCs(1'b0, 8'h00);
    sendByte(8'hFF, 3, 1'b0, 8'h00);
    reset = 1'b1;
    CS = 1'b1;
    SCLK = 1'b0;
    MOSI = 1'b0;
    txModel = '0;
    #1;
    check("async_rst_miso", {31'd0, MISO}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    check("async_rst_rx", {24'd0, slaveDataReceived}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    pulseLoad(8'h25);
    startCs(1'b0, 8'h00);
    sendByte(8'h01, DW, 1'b0, 8'h00);
    endCs();
    check("post_rst_miso", {24'd0, lastTxByte}, 32'h25);
    check("post_rst_rx", {24'd0, slaveDataReceived}, 32'h01);

    // Load colliding with the detected CS fall
    pulseLoad(8'h81);
    startCs(1'b1, 8'h7E);
    sendByte(8'hC3, DW, 1'b0, 8'h00);
    endCs();
    check("collide_first_bit", {31'd0, lastTxByte[DW-1]}, 32'd0);
    check("collide_miso", {24'd0, lastTxByte}, 32'h7E);
    check("collide_rx", {24'd0, slaveDataReceived}, 32'hC3);

    // Randomized sessions
    for (int s = 0; s < 40; s++) begin
      halfPer = $urandom_range(4, 7);
      if ($urandom_range(0, 1) == 1) pulseLoad(DW'($urandom));
      startCs($urandom_range(0, 4) == 0, DW'($urandom));
      nBytes = $urandom_range(1, 3);
      for (int b = 0; b < nBytes; b++) begin
        abortIt = (b == nBytes - 1) && ($urandom_range(0, 4) == 0);
        nBits = abortIt ? $urandom_range(1, DW - 1) : DW;
        sendByte(DW'($urandom), nBits, $urandom_range(0, 1) == 1, DW'($urandom));
      end
      endCs();
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end

    repeat (10) @(posedge clk);
    #1;
    check("pending_done", expCyc.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
